data_tile_fetcher: RTL
======================

# data_tile_fetcher

Parametrised successor to the two-port data memory controller. Holds the input-tile SRAM, replicated into `NUM_CH` read banks and loaded through the scan port, and walks a `block_width × block_height` loop. Each step it issues one read per channel and delivers the `NUM_CH` tiles to the PE arrays as one beat over a valid/ready handshake. New relative to the prior generation: arbitrary channel count, configurable SRAM read latency, a base address, and output backpressure through a credit-limited return FIFO.

## Interface
- `NUM_CH`, 2: parallel read channels / tile lanes per beat.
- `DATA_W`, 512: bits per SRAM word (one packed tile).
- `ADDR_W`, 8: SRAM address width; depth = 2^ADDR_W.
- `CNT_W`, 8: width of `block_width_i` and `block_height_i`.
- `RD_LAT`, 1: SRAM read latency in cycles, ≥1.
- `clk`  in  1  single clock; also the scan clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  starts a loop; sampled in IDLE only.
- `base_addr_i`  in  ADDR_W  first address; latched on start.
- `block_width_i`, `block_height_i`  in  CNT_W each  loop extents; latched on start.
- `size_type_i`  in  1  tile size mode; latched on start.
- `scan_mode_i`  in  1  scan load enable.
- `scan_addr_i`  in  ADDR_W  scan write address.
- `scan_data_i`  in  DATA_W  scan write data.
- `tile_data_o`  out  NUM_CH×DATA_W  tile per channel, channel c in bits [c*DATA_W +: DATA_W].
- `tile_addr_o`  out  NUM_CH×ADDR_W  SRAM address each tile came from.
- `tile_valid_o`  out  1  beat available.
- `tile_ready_i`  in  1  PE side accepts the beat.
- `size_type_o`  out  1  latched `size_type_i`.
- `block_cnt_o`  out  2*CNT_W  beats accepted in the current loop.
- `busy_o`  out  1  state ≠ IDLE.
- `loop_finished_o`  out  1  one-cycle pulse at loop end.

## Operation
- Scan load: a cycle with `scan_mode_i`=1 writes `scan_data_i` to `scan_addr_i` in every bank. Scan has priority.
  - Asserting scan in RUN or DRAIN aborts the loop: FIFO and in-flight reads are flushed, state returns to IDLE, and no `loop_finished_o` pulse is produced.
  - `start_i` is ignored while `scan_mode_i`=1.
- Loop setup: `total = width*height` is computed at 2*CNT_W bits with no overflow. Step k, channel c reads address `(base + k*NUM_CH + c) mod 2^ADDR_W`; the address wraps silently.
- FSM:
  - IDLE → RUN on `start_i`, when total > 0.
  - IDLE → DONE on `start_i`, when total = 0.
  - RUN issues step k whenever `inflight + fifo_count < FIFO_DEPTH`, with `FIFO_DEPTH = RD_LAT+2`. RUN → DRAIN after issuing step total-1.
  - DRAIN → DONE when inflight = 0 and FIFO is empty.
  - DONE → IDLE after one cycle.
- Return path: read data plus its address enter the FIFO RD_LAT cycles after issue. The FIFO head drives `tile_*_o`.
  - A beat pops on `tile_valid_o && tile_ready_i`.
  - `block_cnt_o` increments on each pop and clears on accepted start.
  - The credit rule guarantees the FIFO never overflows; an overflow is an assertion failure.
- `size_type_o` holds its latched value until the next start.

## Timing
- Reset values: `tile_valid_o`=0, `tile_data_o`=0, `tile_addr_o`=0, `block_cnt_o`=0, `size_type_o`=0, `busy_o`=0, `loop_finished_o`=0. State is IDLE, counters are 0, the FIFO is empty. SRAM contents are not reset.
- Start sampled at cycle t: `busy_o`=1 from t+1, first read issued at t+1, first `tile_valid_o` at t+2+RD_LAT.
- Throughput: with `tile_ready_i` held at 1, one beat per cycle, no bubbles.
- Backpressure:
  - With ready low, issue stalls once credits are exhausted.
  - Head data is stable while `tile_valid_o`=1 and ready=0.
  - Resuming restores full rate without losing or duplicating a beat.
- `loop_finished_o` pulses in the cycle the state is DONE. This is one cycle after the last pop, or t+1 for total=0. `busy_o` drops the cycle after.
- Scan-abort: `tile_valid_o`=0 and `busy_o`=0 from the cycle after the scan is sampled.
- Reset mid-loop: all outputs return to reset values immediately, asynchronously.

## Test plan
- Scan-load addresses 0..15 with value = addr. Run NUM_CH=2, base=0, width=2, height=2, ready=1. Expect 4 beats with addresses (0,1),(2,3),(4,5),(6,7) and matching data, first valid at t+3, `loop_finished_o` one cycle after the 4th pop, `block_cnt_o`=4.
- Same loop with ready toggling 1,0,0,1,… Expect the identical ordered beat sequence, stable data during stalls, and FIFO count never above RD_LAT+2.
- base=252, NUM_CH=2, width=4, height=1. Expect addresses (252,253),(254,255),(0,1),(2,3).
- width=0, height=5, start at t. Expect no `tile_valid_o`, `loop_finished_o` at t+1, `block_cnt_o`=0.
- Assert `scan_mode_i` mid-RUN after 2 beats. Expect `busy_o`=0 next cycle, no finish pulse. Then restart and expect a clean full run.
- RD_LAT=3, NUM_CH=4, width=3, height=3, ready=1. Expect 9 back-to-back beats, first valid at t+5. Pulse `reset` low mid-run and expect all outputs at 0 immediately.

Source files
------------

// File: rtl/data_tile_fetcher_if.sv
`default_nettype none
// ============================================================================
// Module   : data_tile_fetcher_if
// Brief    : Tile beat channel from the tile fetcher to the PE arrays.
// Revision : 1.0
// ============================================================================
interface data_tile_fetcher_if #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 512,
    parameter int ADDR_W = 8
);
    logic [NUM_CH*DATA_W-1:0] tile_data_o;
    logic [NUM_CH*ADDR_W-1:0] tile_addr_o;
    logic                     tile_valid_o;
    logic                     tile_ready_i;

    modport master (
        output tile_data_o,
        output tile_addr_o,
        output tile_valid_o,
        input  tile_ready_i
    );

    modport slave (
        input  tile_data_o,
        input  tile_addr_o,
        input  tile_valid_o,
        output tile_ready_i
    );
endinterface
`default_nettype wire

// File: rtl/data_tile_fetcher.sv
`default_nettype none
// ============================================================================
// Module   : data_tile_fetcher
// Brief    : Replicated tile SRAM with scan load, block-loop read sequencer
//            and credit-limited return FIFO feeding the PE arrays.
// Revision : 1.0
// ============================================================================
module data_tile_fetcher #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 512,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8,
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [ADDR_W-1:0]     base_addr_i,
    input  logic [CNT_W-1:0]      block_width_i,
    input  logic [CNT_W-1:0]      block_height_i,
    input  logic                  size_type_i,
    input  logic                  scan_mode_i,
    input  logic [ADDR_W-1:0]     scan_addr_i,
    input  logic [DATA_W-1:0]     scan_data_i,
    data_tile_fetcher_if.master   tile_if,
    output logic                  size_type_o,
    output logic [2*CNT_W-1:0]    block_cnt_o,
    output logic                  busy_o,
    output logic                  loop_finished_o
);
    localparam int FIFO_DEPTH = RD_LAT + 2;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_FW     = $clog2(FIFO_DEPTH + 1);
    localparam int CRD_W      = CNT_FW + 1;
    localparam int TOT_W      = 2 * CNT_W;
    localparam int LANE_AW    = NUM_CH * ADDR_W;
    localparam int LANE_DW    = NUM_CH * DATA_W;
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(NUM_CH);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [TOT_W-1:0]    total_q, total_d, step_q, step_d, block_cnt_q, block_cnt_d;
    logic                size_type_q, size_type_d;
    logic [RD_LAT-1:0]   req_vld_q, req_vld_d;
    logic [LANE_AW-1:0]  req_addr_q [RD_LAT];
    logic [LANE_AW-1:0]  req_addr_d [RD_LAT];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_FW-1:0]   fifo_cnt_q, fifo_cnt_d;
    logic [LANE_DW-1:0]  fifo_data_q [FIFO_DEPTH];
    logic [LANE_AW-1:0]  fifo_addr_q [FIFO_DEPTH];

    logic [LANE_AW-1:0]  issue_addr_w, rd_addr_w;
    logic [LANE_DW-1:0]  rd_data_w;
    logic [TOT_W-1:0]    total_w;
    logic [CRD_W-1:0]    inflight_w, credit_w;
    logic                issue_w, push_w, pop_w, valid_w, abort_w;

    assign total_w  = TOT_W'(block_width_i) * TOT_W'(block_height_i);
    assign valid_w  = (fifo_cnt_q != '0);
    assign pop_w    = valid_w && tile_if.tile_ready_i;
    assign push_w   = req_vld_q[RD_LAT-1];
    assign abort_w  = scan_mode_i && (state_q == S_RUN || state_q == S_DRAIN);
    assign credit_w = inflight_w + CRD_W'(fifo_cnt_q);
    assign issue_w  = (state_q == S_RUN) && !scan_mode_i && (credit_w < CRD_W'(FIFO_DEPTH));

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        assign issue_addr_w[c*ADDR_W +: ADDR_W] = addr_q + ADDR_W'(c);
    end

    // The address is delayed ahead of the SRAM so the read data needs no pipeline.
    if (RD_LAT == 1) begin : g_rd_direct
        assign rd_addr_w = issue_addr_w;
    end else begin : g_rd_piped
        assign rd_addr_w = req_addr_q[RD_LAT-2];
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_bank
        logic [DATA_W-1:0] mem [2**ADDR_W];
        logic [DATA_W-1:0] rd_q;
        always_ff @(posedge clk) begin
            if (scan_mode_i) mem[scan_addr_i] <= scan_data_i;
            rd_q <= mem[rd_addr_w[c*ADDR_W +: ADDR_W]];
        end
        assign rd_data_w[c*DATA_W +: DATA_W] = rd_q;
    end

    always_comb begin
        inflight_w = '0;
        for (int i = 0; i < RD_LAT; i++) inflight_w = inflight_w + CRD_W'(req_vld_q[i]);
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        total_d     = total_q;
        step_d      = step_q;
        block_cnt_d = block_cnt_q;
        size_type_d = size_type_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fifo_cnt_d  = fifo_cnt_q + CNT_FW'(push_w) - CNT_FW'(pop_w);
        req_vld_d[0]  = issue_w;
        req_addr_d[0] = issue_addr_w;
        for (int i = 1; i < RD_LAT; i++) begin
            req_vld_d[i]  = req_vld_q[i-1];
            req_addr_d[i] = req_addr_q[i-1];
        end
        if (push_w) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        if (pop_w) begin
            rd_ptr_d    = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
            block_cnt_d = block_cnt_q + TOT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start_i && !scan_mode_i) begin
                    addr_d      = base_addr_i;
                    total_d     = total_w;
                    step_d      = '0;
                    block_cnt_d = '0;
                    size_type_d = size_type_i;
                    state_d     = (total_w == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (issue_w) begin
                    addr_d = addr_q + ADDR_STEP;
                    step_d = step_q + TOT_W'(1);
                    if (step_q == total_q - TOT_W'(1)) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Finish in the same cycle as the final pop so the pulse lands one cycle later.
                if (inflight_w == '0 &&
                    (fifo_cnt_q == '0 || (fifo_cnt_q == CNT_FW'(1) && pop_w)))
                    state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        if (abort_w) begin
            state_d    = S_IDLE;
            req_vld_d  = '0;
            fifo_cnt_d = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            total_q     <= '0;
            step_q      <= '0;
            block_cnt_q <= '0;
            size_type_q <= 1'b0;
            req_vld_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            for (int i = 0; i < RD_LAT; i++) req_addr_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            total_q     <= total_d;
            step_q      <= step_d;
            block_cnt_q <= block_cnt_d;
            size_type_q <= size_type_d;
            req_vld_q   <= req_vld_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
            for (int i = 0; i < RD_LAT; i++) req_addr_q[i] <= req_addr_d[i];
        end
    end

    always_ff @(posedge clk) begin
        if (push_w) begin
            fifo_data_q[wr_ptr_q] <= rd_data_w;
            fifo_addr_q[wr_ptr_q] <= req_addr_q[RD_LAT-1];
        end
    end

    a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(push_w && !pop_w && fifo_cnt_q == CNT_FW'(FIFO_DEPTH)));

    // Head gated by valid so the outputs read zero after reset and when empty.
    assign tile_if.tile_valid_o = valid_w;
    assign tile_if.tile_data_o  = valid_w ? fifo_data_q[rd_ptr_q] : '0;
    assign tile_if.tile_addr_o  = valid_w ? fifo_addr_q[rd_ptr_q] : '0;
    assign size_type_o          = size_type_q;
    assign block_cnt_o          = block_cnt_q;
    assign busy_o               = (state_q != S_IDLE);
    assign loop_finished_o      = (state_q == S_DONE);
endmodule
`default_nettype wire
